// File: rtl/spw_rx_decoder.sv
// SpaceWire receive decoder: recovers bits from the D/S line pair, assembles
// characters, checks parity and escape sequences, and hands N-chars to the
// receive FIFO. Flags NULL/FCT/time-code arrivals and latches link errors.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | receiver disabled, flags cleared
// WAIT_BIT | enabled, waiting for the first bit event on the link
// RUN      | decoding characters, disconnect timer running
// ERR      | an error flag is set; decoding halted until rx_enable drops
module spw_rx_decoder #(
  parameter int DISC_CYCLES = 85,
  parameter int DWIDTH      = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_enable,
  input  logic              d_in,
  input  logic              s_in,
  input  logic              f_full,
  output logic              wr_en,
  output logic [DWIDTH-1:0] data_out,
  output logic              got_null,
  output logic              got_fct,
  output logic              got_time_code,
  output logic [7:0]        time_out,
  output logic              first_null_seen,
  output logic              parity_error,
  output logic              escape_error,
  output logic              disconnect_error,
  output logic              rx_overflow
);

  localparam int CW = $clog2(DISC_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT_BIT, RUN, ERR} state_t;

  state_t            state_q, state_d;
  logic              d_q, s_q;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic              par_bit_q, par_bit_d;
  logic              ctrl_q, ctrl_d;
  logic [7:0]        shift_q, shift_d;
  logic              run_par_q, run_par_d;
  logic              prev_par_q, prev_par_d;
  logic              first_char_q, first_char_d;
  logic              esc_q, esc_d;
  logic [CW-1:0]     disc_q, disc_d;
  logic              wr_en_q, wr_en_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              null_q, null_d;
  logic              fct_q, fct_d;
  logic              tc_q, tc_d;
  logic [7:0]        time_q, time_d;
  logic              fns_q, fns_d;
  logic              perr_q, perr_d;
  logic              eerr_q, eerr_d;
  logic              derr_q, derr_d;
  logic              ovf_q, ovf_d;

  logic              d_chg, s_chg, bit_evt, both_chg;
  logic [7:0]        shifted;
  logic              char_done;
  logic [8:0]        nchar;
  logic              do_write;
  logic [CW-1:0]     disc_inc;

  assign d_chg    = d_in ^ d_q;
  assign s_chg    = s_in ^ s_q;
  assign bit_evt  = d_chg ^ s_chg;
  assign both_chg = d_chg & s_chg;
  assign shifted  = {d_in, shift_q[7:1]};
  assign disc_inc = disc_q + CW'(1);

  // Next-state, bit assembly, character decode and output pulse generation.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    par_bit_d    = par_bit_q;
    ctrl_d       = ctrl_q;
    shift_d      = shift_q;
    run_par_d    = run_par_q;
    prev_par_d   = prev_par_q;
    first_char_d = first_char_q;
    esc_d        = esc_q;
    disc_d       = disc_q;
    wr_en_d      = 1'b0;
    data_d       = data_q;
    null_d       = 1'b0;
    fct_d        = 1'b0;
    tc_d         = 1'b0;
    time_d       = time_q;
    fns_d        = fns_q;
    perr_d       = perr_q;
    eerr_d       = eerr_q;
    derr_d       = derr_q;
    ovf_d        = ovf_q;
    char_done    = 1'b0;
    nchar        = 9'h000;
    do_write     = 1'b0;

    if (!rx_enable) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      disc_d    = '0;
      esc_d     = 1'b0;
      fns_d     = 1'b0;
      perr_d    = 1'b0;
      eerr_d    = 1'b0;
      derr_d    = 1'b0;
      ovf_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = WAIT_BIT;
          bit_cnt_d    = 4'd0;
          disc_d       = '0;
          esc_d        = 1'b0;
          first_char_d = 1'b1;
        end
        WAIT_BIT, RUN: begin
          if (both_chg) begin
            derr_d = 1'b1;
          end else if (bit_evt) begin
            state_d = RUN;
            disc_d  = '0;
            case (bit_cnt_q)
              4'd0: begin
                par_bit_d = d_in;
                bit_cnt_d = 4'd1;
              end
              4'd1: begin
                ctrl_d       = d_in;
                run_par_d    = 1'b0;
                bit_cnt_d    = 4'd2;
                first_char_d = 1'b0;
                // parity spans the previous character's payload plus P and flag
                if (!first_char_q && !(prev_par_q ^ par_bit_q ^ d_in))
                  perr_d = 1'b1;
              end
              default: begin
                shift_d   = shifted;
                run_par_d = run_par_q ^ d_in;
                bit_cnt_d = bit_cnt_q + 4'd1;
                if ((ctrl_q && bit_cnt_q == 4'd3) || (!ctrl_q && bit_cnt_q == 4'd9)) begin
                  char_done  = 1'b1;
                  bit_cnt_d  = 4'd0;
                  prev_par_d = run_par_q ^ d_in;
                end
              end
            endcase
          end else if (state_q == RUN) begin
            disc_d = disc_inc;
            if (disc_inc == CW'(DISC_CYCLES))
              derr_d = 1'b1;
          end

          // Control code is the two payload bits taken LSB-first.
          if (char_done) begin
            if (ctrl_q) begin
              case (shifted[7:6])
                2'b11: begin
                  if (esc_q) begin
                    if (fns_q) eerr_d = 1'b1;
                  end else begin
                    esc_d = 1'b1;
                  end
                end
                2'b00: begin
                  if (esc_q) begin
                    null_d = 1'b1;
                    fns_d  = 1'b1;
                    esc_d  = 1'b0;
                  end else if (fns_q) begin
                    fct_d = 1'b1;
                  end
                end
                default: begin
                  if (esc_q) begin
                    esc_d = 1'b0;
                    if (fns_q) eerr_d = 1'b1;
                  end else if (fns_q) begin
                    do_write = 1'b1;
                    nchar    = (shifted[7:6] == 2'b01) ? 9'h100 : 9'h101;
                  end
                end
              endcase
            end else begin
              if (esc_q) begin
                esc_d = 1'b0;
                if (fns_q) begin
                  tc_d   = 1'b1;
                  time_d = shifted;
                end
              end else if (fns_q) begin
                do_write = 1'b1;
                nchar    = {1'b0, shifted};
              end
            end
          end

          if (do_write) begin
            if (f_full) begin
              ovf_d = 1'b1;
            end else begin
              wr_en_d = 1'b1;
              data_d  = DWIDTH'(nchar);
            end
          end

          if (perr_d || eerr_d || derr_d || ovf_d)
            state_d = ERR;
        end
        default: begin
          // ERR: hold everything until rx_enable is dropped
        end
      endcase
    end
  end

  // State and datapath registers; async reset returns to a clean idle link.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      d_q          <= 1'b0;
      s_q          <= 1'b0;
      bit_cnt_q    <= 4'd0;
      par_bit_q    <= 1'b0;
      ctrl_q       <= 1'b0;
      shift_q      <= 8'h00;
      run_par_q    <= 1'b0;
      prev_par_q   <= 1'b0;
      first_char_q <= 1'b0;
      esc_q        <= 1'b0;
      disc_q       <= '0;
      wr_en_q      <= 1'b0;
      data_q       <= '0;
      null_q       <= 1'b0;
      fct_q        <= 1'b0;
      tc_q         <= 1'b0;
      time_q       <= 8'h00;
      fns_q        <= 1'b0;
      perr_q       <= 1'b0;
      eerr_q       <= 1'b0;
      derr_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      d_q          <= d_in;
      s_q          <= s_in;
      bit_cnt_q    <= bit_cnt_d;
      par_bit_q    <= par_bit_d;
      ctrl_q       <= ctrl_d;
      shift_q      <= shift_d;
      run_par_q    <= run_par_d;
      prev_par_q   <= prev_par_d;
      first_char_q <= first_char_d;
      esc_q        <= esc_d;
      disc_q       <= disc_d;
      wr_en_q      <= wr_en_d;
      data_q       <= data_d;
      null_q       <= null_d;
      fct_q        <= fct_d;
      tc_q         <= tc_d;
      time_q       <= time_d;
      fns_q        <= fns_d;
      perr_q       <= perr_d;
      eerr_q       <= eerr_d;
      derr_q       <= derr_d;
      ovf_q        <= ovf_d;
    end
  end

  assign wr_en            = wr_en_q;
  assign data_out         = data_q;
  assign got_null         = null_q;
  assign got_fct          = fct_q;
  assign got_time_code    = tc_q;
  assign time_out         = time_q;
  assign first_null_seen  = fns_q;
  assign parity_error     = perr_q;
  assign escape_error     = eerr_q;
  assign disconnect_error = derr_q;
  assign rx_overflow      = ovf_q;

endmodule

// File: tb/tb_spw_rx_decoder.sv
// Bench for spw_rx_decoder: a D/S line encoder drives characters at 4 clocks
// per bit; expected FIFO writes and pulses are queued as stimulus is issued
// and a monitor on the falling edge pops and compares them.
module tb_spw_rx_decoder;

  localparam logic [1:0] K_WR = 2'd0, K_NULL = 2'd1, K_FCT = 2'd2, K_TC = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [8:0] val;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_enable;
  logic       d_in, s_in, f_full;
  logic       wr_en;
  logic [8:0] data_out;
  logic       got_null, got_fct, got_time_code;
  logic [7:0] time_out;
  logic       first_null_seen, parity_error, escape_error, disconnect_error, rx_overflow;

  ev_t exp_q[$];
  int  nchk = 0;
  int  nerr = 0;
  logic d_cur, s_cur;
  logic prev_par;

  spw_rx_decoder #(.DISC_CYCLES(85), .DWIDTH(9)) dut (
    .clock(clock), .reset(reset), .rx_enable(rx_enable),
    .d_in(d_in), .s_in(s_in), .f_full(f_full),
    .wr_en(wr_en), .data_out(data_out),
    .got_null(got_null), .got_fct(got_fct), .got_time_code(got_time_code),
    .time_out(time_out), .first_null_seen(first_null_seen),
    .parity_error(parity_error), .escape_error(escape_error),
    .disconnect_error(disconnect_error), .rx_overflow(rx_overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [8:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input logic [1:0] k, input logic [8:0] v);
    ev_t e;
    nchk++;
    if (exp_q.size() == 0) begin
      nerr++;
      $display("FAIL unexpected_output: got kind=%0d val=%h, expected nothing", k, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.val !== v) begin
        nerr++;
        $display("FAIL output_event: got kind=%0d val=%h, expected kind=%0d val=%h",
                 k, v, e.kind, e.val);
      end
    end
  endtask

  // monitor: every pulse/write is matched against the scoreboard
  initial begin
    forever begin
      @(negedge clock);
      if (wr_en)         check_ev(K_WR, data_out);
      if (got_null)      check_ev(K_NULL, 9'h000);
      if (got_fct)       check_ev(K_FCT, 9'h000);
      if (got_time_code) check_ev(K_TC, {1'b0, time_out});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // data/strobe encoding: data carries the bit, strobe toggles when data does not
  task automatic send_bit(input logic b);
    if (b != d_cur) d_cur = ~d_cur;
    else            s_cur = ~s_cur;
    d_in = d_cur;
    s_in = s_cur;
    repeat (4) @(negedge clock);
  endtask

  task automatic send_char(input logic ctrl, input logic [7:0] v, input logic flip);
    logic p;
    p = 1'b1 ^ prev_par ^ ctrl ^ flip;
    send_bit(p);
    send_bit(ctrl);
    if (ctrl) begin
      for (int i = 0; i < 2; i++) send_bit(v[i]);
      prev_par = ^v[1:0];
    end else begin
      for (int i = 0; i < 8; i++) send_bit(v[i]);
      prev_par = ^v;
    end
  endtask

  task automatic send_null();
    send_char(1'b1, 8'h03, 1'b0);
    send_char(1'b1, 8'h00, 1'b0);
  endtask

  task automatic restart_link();
    rx_enable = 1'b0;
    repeat (3) @(negedge clock);
    chk("flags_cleared", {28'd0, parity_error, escape_error, disconnect_error, rx_overflow}, 32'd0);
    rx_enable = 1'b1;
    prev_par  = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; rx_enable = 1'b0; f_full = 1'b0;
    d_in = 1'b0; s_in = 1'b0; d_cur = 1'b0; s_cur = 1'b0; prev_par = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_data_out", data_out, 0);
    chk("reset_flags", {27'd0, first_null_seen, parity_error, escape_error, disconnect_error, rx_overflow}, 0);
    reset = 1'b1;
    @(negedge clock);
    rx_enable = 1'b1;
    repeat (3) @(negedge clock);

    // NULL, NULL, data 0xA5
    expect_ev(K_NULL, 0);
    send_char(1'b1, 8'h03, 1'b0);
    chk("fns_after_esc_only", first_null_seen, 0);
    send_char(1'b1, 8'h00, 1'b0);
    chk("fns_after_first_null", first_null_seen, 1);
    expect_ev(K_NULL, 0);
    send_null();
    expect_ev(K_WR, 9'h0A5);
    send_char(1'b0, 8'hA5, 1'b0);

    // EOP, EEP, FCT
    expect_ev(K_WR, 9'h100);
    send_char(1'b1, 8'h01, 1'b0);
    expect_ev(K_WR, 9'h101);
    send_char(1'b1, 8'h02, 1'b0);
    expect_ev(K_FCT, 0);
    send_char(1'b1, 8'h00, 1'b0);

    // time code
    expect_ev(K_TC, 9'h03C);
    send_char(1'b1, 8'h03, 1'b0);
    send_char(1'b0, 8'h3C, 1'b0);
    chk("time_out", time_out, 8'h3C);

    // bad parity then ESC+EOP: halted, no writes, no escape error
    send_char(1'b0, 8'h55, 1'b1);
    chk("parity_error_set", parity_error, 1);
    send_char(1'b1, 8'h03, 1'b0);
    send_char(1'b1, 8'h01, 1'b0);
    chk("parity_error_held", parity_error, 1);
    chk("no_escape_in_err", escape_error, 0);
    restart_link();

    // disconnect: last event at edge E; send_bit returns after E+3
    expect_ev(K_NULL, 0);
    send_null();
    repeat (81) @(negedge clock);
    chk("disconnect_at_84", disconnect_error, 0);
    @(negedge clock);
    chk("disconnect_at_85", disconnect_error, 1);
    restart_link();

    // overflow
    expect_ev(K_NULL, 0);
    send_null();
    f_full = 1'b1;
    send_char(1'b0, 8'h11, 1'b0);
    chk("rx_overflow", rx_overflow, 1);
    f_full = 1'b0;
    restart_link();

    // reset mid data character
    expect_ev(K_NULL, 0);
    send_null();
    send_bit(1'b1 ^ prev_par);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b0;
    #1;
    chk("midreset_data_out", data_out, 0);
    chk("midreset_time_out", time_out, 0);
    chk("midreset_outputs", {26'd0, wr_en, got_null, got_fct, got_time_code, first_null_seen, parity_error}, 0);
    d_in = 1'b0; s_in = 1'b0; d_cur = 1'b0; s_cur = 1'b0; prev_par = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("fns_after_reset", first_null_seen, 0);
    send_char(1'b0, 8'h33, 1'b0);
    expect_ev(K_NULL, 0);
    send_null();
    chk("fns_restart", first_null_seen, 1);
    expect_ev(K_WR, 9'h05A);
    send_char(1'b0, 8'h5A, 1'b0);

    // ESC ESC
    send_char(1'b1, 8'h03, 1'b0);
    send_char(1'b1, 8'h03, 1'b0);
    chk("escape_error", escape_error, 1);

    repeat (10) @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
